sa_input_skewer: RTL and testbench
==================================

Name: sa_input_skewer

Overview:
Feeder stage directly upstream of the NxN systolic PE array. It accepts one K-step of operands per handshake: an N-lane A vector for the column tops and an N-lane B vector for the row lefts. It applies the triangular skew that lane i needs (i extra cycles) and drives the array edge buses. It also sequences each tile: an accumulator clear via load_weights, K compute beats, then a zero-flush so the last products reach PE(N-1,N-1).

Parameters:
BITWIDTH, 4, operand width per lane (matches PE BITWIDTH)
N, 4, array dimension (lanes per vector)
KMAX, 255, maximum beats per tile; k_len width KW = $clog2(KMAX+1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  tile start request, sampled only in IDLE
k_len  input  KW  beats in tile, sampled with start; 0 means start is ignored
in_valid  input  1  A/B beat valid
in_ready  output  1  beat accepted when in_valid && in_ready
a_vec  input  N*BITWIDTH  A lanes; lane j = bits [j*BITWIDTH +: BITWIDTH], goes to column j top
b_vec  input  N*BITWIDTH  B lanes; lane i, goes to row i left
top_data  output  N*BITWIDTH  skewed column-top data to PE in_data of row 0
left_weight  output  N*BITWIDTH  skewed row-left data to PE in_weight of column 0
compute_en  output  1  array-wide compute enable
load_weights  output  1  array-wide accumulator clear, one-cycle pulse
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, tile complete, array results final

Behaviour:
- Reset: state=IDLE, all skew registers=0, beat/flush counters=0. Outputs: top_data=0, left_weight=0, compute_en=0, load_weights=0, in_ready=0, busy=0, done=0. Reset overrides everything, including mid-tile.
- Clear before use: reset wins over any other event in the same cycle.
- FSM states: IDLE, CLEAR, STREAM, FLUSH.
- IDLE: if start && k_len!=0, latch k_len and go to CLEAR. start with k_len==0 is ignored.
- start outside IDLE is ignored and not queued.
- CLEAR: lasts exactly one cycle. load_weights=1 and all skew registers are zeroed; then go to STREAM.
- STREAM: in_ready=1 (combinational from state).
  - Each accepted beat shifts every skew chain one stage and decrements the remaining count.
  - After the K-th accept, go to FLUSH.
  - in_valid low means no shift and compute_en=0 next cycle, so the array holds; stalls of any length are legal.
- FLUSH: in_ready=0. Shifts zeros into stage 0 of every chain each cycle for exactly 2*(N-1) cycles, then goes to IDLE with done=1 for one cycle.
  - For N=1, FLUSH is 0 cycles: go straight to IDLE with done.
- Skew structure:
  - Lane i of each bus is a chain of i+1 registers; lane 0 is one register.
  - All chains advance only on shift_en, where shift_en = (STREAM && in_valid) || FLUSH.
- Output timing:
  - compute_en is a register loaded with shift_en, so it is aligned with the first register stage.
  - Lane i output = last register of chain i.
  - A value accepted at edge e appears on lane 0 after edge e, and on lane i after i further shift_en edges.
- Latency: tile cycles = 1 (CLEAR) + K (no stalls) + 2(N-1) (FLUSH), then done.
- Total compute_en-high cycles per tile = K + 2(N-1).
- Products during FLUSH are zero, so PE results are final when done fires.
- Widths: pure data movement, no arithmetic on operands. Counters saturate-free within KMAX.
- load_weights and compute_en are never high in the same cycle.
- busy=1 exactly from the CLEAR cycle through the last FLUSH cycle.

Test Plan:
- Reset values: after reset, all outputs are 0, including in_ready=0 and busy=0.
- Single beat: N=4, start, k_len=1. Expect load_weights in cycle 1. Drive a=(1,2,3,4), b=(5,6,7,8) accepted in cycle 2. Expect:
  - cycle 3: top_data lanes=(1,0,0,0), left_weight=(5,0,0,0), compute_en=1
  - cycle 4: lanes=(0,2,0,0)/(0,6,0,0)
  - cycle 5: lane 2 = 3/7
  - cycle 6: lane 3 = 4/8
  - compute_en high cycles 3..9 (7 total), done pulse cycle 9.
- Stall: K=3 with in_valid low for 2 cycles between beats 1 and 2. Expect skew outputs frozen and compute_en=0 during the gap, lane ordering intact, done 2 cycles later than the no-stall run.
- Ignored starts: start with k_len=0 gives no state change. start during STREAM gives no effect on the running tile and no second tile.
- Reset mid-tile: assert reset mid-STREAM after 2 of K=5 beats. Next cycle, all outputs are 0 and state is IDLE. A fresh tile with K=1 then completes normally.
- Back-to-back: assert start in the done cycle. Second tile's load_weights arrives the next cycle. Integrated with a 4x4 PE array, A=I, B=[1..16] gives results equal to B.

Source files
------------

// File: rtl/sa_input_skewer.sv
// sa_input_skewer: feeder stage for an NxN systolic PE array.
// Accepts one K-step of A/B operands per handshake, applies a triangular skew
// (lane i delayed i extra shift cycles) and sequences each tile as
// CLEAR (accumulator clear) -> STREAM (K beats) -> FLUSH (2*(N-1) zero beats).
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, k_len      tile request and beat count, sampled in IDLE only
//   in_valid/in_ready beat handshake; a_vec/b_vec are the N-lane operands
//   top_data          skewed column-top data (lane j -> column j, row 0)
//   left_weight       skewed row-left data (lane i -> row i, column 0)
//   compute_en        array-wide compute enable
//   load_weights      array-wide accumulator clear (one cycle, CLEAR state)
//   busy              high outside IDLE
//   done              one-cycle pulse, array results final
module sa_input_skewer #(
    parameter int unsigned BITWIDTH = 4,
    parameter int unsigned N        = 4,
    parameter int unsigned KMAX     = 255,
    localparam int unsigned KW      = $clog2(KMAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*BITWIDTH-1:0] a_vec,
    input  logic [N*BITWIDTH-1:0] b_vec,
    output logic [N*BITWIDTH-1:0] top_data,
    output logic [N*BITWIDTH-1:0] left_weight,
    output logic                  compute_en,
    output logic                  load_weights,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FLUSH_LEN  = 2 * (N - 1);
    localparam int unsigned FLUSH_LAST = (FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0;
    localparam int unsigned FW         = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            compute_en_q;
    logic            done_q, done_d;
    logic            shift_en;
    logic            clear_chains;
    logic            feed_data;

    // State and sequencing registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            compute_en_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            compute_en_q <= shift_en;
            done_q       <= done_d;
        end
    end

    // Next-state, counters and shift enable
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        shift_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (k_len != '0)) begin
                    beat_cnt_d = k_len;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (in_valid) begin
                    shift_en   = 1'b1;
                    beat_cnt_d = beat_cnt_q - KW'(1);
                    if (beat_cnt_q == KW'(1)) begin
                        // A 1-lane array has nothing to flush
                        if (FLUSH_LEN == 0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = FW'(FLUSH_LAST);
                        end
                    end
                end
            end
            S_FLUSH: begin
                shift_en    = 1'b1;
                flush_cnt_d = flush_cnt_q - FW'(1);
                if (flush_cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign clear_chains = (state_q == S_CLEAR);
    // Zeros enter stage 0 during FLUSH so trailing products are zero
    assign feed_data    = (state_q == S_STREAM);

    // Triangular skew: lane i is a chain of i+1 registers on each bus
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [BITWIDTH-1:0] a_ch_q [0:i];
        logic [BITWIDTH-1:0] b_ch_q [0:i];

        always_ff @(posedge clk) begin
            if (reset || clear_chains) begin
                for (int s = 0; s <= i; s++) begin
                    a_ch_q[s] <= '0;
                    b_ch_q[s] <= '0;
                end
            end else if (shift_en) begin
                a_ch_q[0] <= feed_data ? a_vec[i*BITWIDTH +: BITWIDTH] : '0;
                b_ch_q[0] <= feed_data ? b_vec[i*BITWIDTH +: BITWIDTH] : '0;
                for (int s = 1; s <= i; s++) begin
                    a_ch_q[s] <= a_ch_q[s-1];
                    b_ch_q[s] <= b_ch_q[s-1];
                end
            end
        end

        assign top_data[i*BITWIDTH +: BITWIDTH]    = a_ch_q[i];
        assign left_weight[i*BITWIDTH +: BITWIDTH] = b_ch_q[i];
    end

    // Status outputs are direct decodes of the state register
    assign in_ready     = (state_q == S_STREAM);
    assign busy         = (state_q != S_IDLE);
    assign load_weights = (state_q == S_CLEAR);
    assign compute_en   = compute_en_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sa_input_skewer.sv
// Self-checking bench for sa_input_skewer: a history-based reference model
// compared every cycle, plus hand-computed checks of the directed scenarios.
module tb_sa_input_skewer;

    localparam int unsigned BW   = 4;
    localparam int unsigned N    = 4;
    localparam int unsigned KMAX = 255;
    localparam int unsigned KW   = 8;
    localparam int unsigned FL   = 2 * (N - 1);

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [KW-1:0]     k_len;
    logic [N*BW-1:0]   a_vec, b_vec, top_data, left_weight;
    logic              in_ready, compute_en, load_weights, busy, done;

    int checks = 0;
    int errors = 0;

    sa_input_skewer #(.BITWIDTH(BW), .N(N), .KMAX(KMAX)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .b_vec(b_vec),
        .top_data(top_data), .left_weight(left_weight),
        .compute_en(compute_en), .load_weights(load_weights),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tile phase, remaining beats, and the history of vectors
    // pushed into the skew chains. Lane i shows the vector pushed i shifts ago.
    int              m_mode = 0; // 0 idle, 1 clear, 2 stream, 3 flush
    int              m_left = 0;
    int              m_flush = 0;
    bit              m_ce = 0;
    bit              m_done = 0;
    bit              chk_en = 0;
    logic [N*BW-1:0] ha[$];
    logic [N*BW-1:0] hb[$];

    function automatic logic [N*BW-1:0] exp_bus(input bit use_b);
        logic [N*BW-1:0] r;
        logic [N*BW-1:0] v;
        int sz;
        r  = '0;
        sz = use_b ? hb.size() : ha.size();
        for (int i = 0; i < N; i++) begin
            if (sz > i) begin
                v = use_b ? hb[sz-1-i] : ha[sz-1-i];
                r[i*BW +: BW] = v[i*BW +: BW];
            end
        end
        return r;
    endfunction

    task automatic push_hist(input logic [N*BW-1:0] a, input logic [N*BW-1:0] b);
        ha.push_back(a);
        hb.push_back(b);
        if (ha.size() > N) void'(ha.pop_front());
        if (hb.size() > N) void'(hb.pop_front());
    endtask

    always @(posedge clk) begin : model
        bit ce_n, done_n;
        ce_n   = 1'b0;
        done_n = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_left  = 0;
            m_flush = 0;
            ha.delete();
            hb.delete();
        end else begin
            case (m_mode)
                0: if (start && k_len != 0) begin
                    m_left = int'(k_len);
                    m_mode = 1;
                end
                1: begin
                    ha.delete();
                    hb.delete();
                    m_mode = 2;
                end
                2: if (in_valid) begin
                    push_hist(a_vec, b_vec);
                    ce_n   = 1'b1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode  = 3;
                        m_flush = FL;
                    end
                end
                default: begin
                    push_hist('0, '0);
                    ce_n    = 1'b1;
                    m_flush = m_flush - 1;
                    if (m_flush == 0) begin
                        m_mode = 0;
                        done_n = 1'b1;
                    end
                end
            endcase
        end
        m_ce   = ce_n;
        m_done = done_n;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("top_data", 64'(top_data), 64'(exp_bus(1'b0)));
            check("left_weight", 64'(left_weight), 64'(exp_bus(1'b1)));
            check("compute_en", 64'(compute_en), 64'(m_ce));
            check("done", 64'(done), 64'(m_done));
            check("in_ready", 64'(in_ready), 64'(m_mode == 2));
            check("busy", 64'(busy), 64'(m_mode != 0));
            check("load_weights", 64'(load_weights), 64'(m_mode == 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
    endtask

    initial begin : stim
        int ce_cnt, done_cyc, done_cnt;
        logic [N*BW-1:0] snap_t, snap_l;
        bit seen;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_top", 64'(top_data), 64'h0);
        check("rst_left", 64'(left_weight), 64'h0);
        check("rst_ready_busy", 64'({in_ready, busy, done, compute_en, load_weights}), 64'h0);
        tick();

        // Single beat, K=1
        start = 1'b1; k_len = 8'd1;
        tick();                                   // cycle 1
        start = 1'b0;
        check("sb_load_weights", 64'(load_weights), 64'h1);
        in_valid = 1'b1; a_vec = 16'h4321; b_vec = 16'h8765;
        tick();                                   // cycle 2
        check("sb_in_ready", 64'(in_ready), 64'h1);
        tick();                                   // cycle 3
        in_valid = 1'b0;
        check("sb_c3_top", 64'(top_data), 64'h0001);
        check("sb_c3_left", 64'(left_weight), 64'h0005);
        check("sb_c3_ce", 64'(compute_en), 64'h1);
        ce_cnt = 1; done_cyc = -1;
        for (int c = 4; c <= 12; c++) begin
            tick();
            if (c == 4) begin
                check("sb_c4_top", 64'(top_data), 64'h0020);
                check("sb_c4_left", 64'(left_weight), 64'h0060);
            end
            if (c == 5) begin
                check("sb_c5_top", 64'(top_data), 64'h0300);
                check("sb_c5_left", 64'(left_weight), 64'h0700);
            end
            if (c == 6) begin
                check("sb_c6_top", 64'(top_data), 64'h4000);
                check("sb_c6_left", 64'(left_weight), 64'h8000);
            end
            ce_cnt += int'(compute_en);
            if (done && done_cyc < 0) done_cyc = c;
        end
        check("sb_ce_count", 64'(ce_cnt), 64'd7);
        check("sb_done_cycle", 64'(done_cyc), 64'd9);

        // Stall: K=3, two idle cycles between beats 1 and 2
        start = 1'b1; k_len = 8'd3; done_cyc = -1; snap_t = '0; snap_l = '0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            if (c == 3) begin
                snap_t = top_data;
                snap_l = left_weight;
            end
            if (c == 4 || c == 5) begin
                check("st_frozen_top", 64'(top_data), 64'(snap_t));
                check("st_frozen_left", 64'(left_weight), 64'(snap_l));
                check("st_gap_ce", 64'(compute_en), 64'h0);
            end
            if (done && done_cyc < 0) done_cyc = c;
            in_valid = (c == 2 || c == 5 || c == 6);
            a_vec = 16'($urandom); b_vec = 16'($urandom);
        end
        in_valid = 1'b0;
        check("st_done_cycle", 64'(done_cyc), 64'd13);

        // start with k_len=0 is ignored
        start = 1'b1; k_len = 8'd0;
        tick();
        start = 1'b0;
        check("k0_busy", 64'(busy), 64'h0);
        tick();
        check("k0_busy2", 64'(busy), 64'h0);

        // start held during a running tile: exactly one tile
        start = 1'b1; k_len = 8'd2; in_valid = 1'b1; ce_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = (c <= 8);
            k_len = 8'd4;
            a_vec = 16'($urandom); b_vec = 16'($urandom);
            ce_cnt   += int'(compute_en);
            done_cnt += int'(done);
        end
        start = 1'b0; in_valid = 1'b0;
        check("ign_done_count", 64'(done_cnt), 64'd1);
        check("ign_ce_count", 64'(ce_cnt), 64'd8);

        // Reset mid-STREAM after 2 of 5 beats
        start = 1'b1; k_len = 8'd5;
        tick();                                   // cycle 1
        start = 1'b0; in_valid = 1'b1; a_vec = 16'h1111; b_vec = 16'h2222;
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        tick();                                   // cycle 4
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check("mr_top", 64'(top_data), 64'h0);
        check("mr_left", 64'(left_weight), 64'h0);
        check("mr_flags", 64'({in_ready, busy, done, compute_en, load_weights}), 64'h0);
        start = 1'b1; k_len = 8'd1; in_valid = 1'b1; done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            done_cnt += int'(done);
        end
        in_valid = 1'b0;
        check("mr_fresh_done", 64'(done_cnt), 64'd1);

        // Back-to-back: start in the done cycle
        start = 1'b1; k_len = 8'd1; in_valid = 1'b1; seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        check("b2b_done_seen", 64'(seen), 64'h1);
        start = 1'b1; k_len = 8'd2;
        tick();
        start = 1'b0;
        check("b2b_load_weights", 64'(load_weights), 64'h1);
        for (int c = 0; c < 15; c++) tick();
        in_valid = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 7) == 0);
            k_len    = 8'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            a_vec    = 16'($urandom);
            b_vec    = 16'($urandom);
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
